// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared datapath width default and fetch controller state encodings
package fetch_ctrl_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_PEND     = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [1:0] S_HALT     = 2'd3;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and increment enable
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage stall/redirect/halt controller with saturating stall and flush counters
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             mem_busy,
  input  logic             br_taken,
  input  logic [WIDTH-3:0] br_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             if_stall,
  output logic             if_branch,
  output logic [WIDTH-3:0] if_branch_addr,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_ex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [1:0]       state, state_nxt;
  logic [WIDTH-3:0] tgt;
  logic             redir;
  always_comb
    state_nxt = state == S_RUN      ? (br_taken ? (mem_busy ? S_PEND : S_REDIRECT)
                                                : (halt_req && !mem_busy ? S_HALT : S_RUN))
              : state == S_PEND     ? (mem_busy ? S_PEND : S_REDIRECT)
              : state == S_REDIRECT ? (halt_req ? S_HALT : S_RUN)
              :                       (resume ? S_RUN : S_HALT);
  // target is only captured from RUN so a pending redirect cannot be overwritten
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_RUN;
      tgt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_RUN && br_taken) tgt <= br_target;
    end
  assign redir          = state == S_REDIRECT;
  assign halted         = state == S_HALT;
  assign if_branch      = redir;
  assign if_branch_addr = redir ? tgt : '0;
  assign flush_id       = redir;
  assign flush_ex       = redir;
  // stall is suppressed in REDIRECT so IF never sees stall and branch together
  assign if_stall  = !redir && (halted || mem_busy || (load_use && !br_taken && state != S_PEND));
  assign bubble_ex = load_use && !mem_busy && !br_taken && state == S_RUN;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (if_stall),
    .q   (stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (redir),
    .q   (flush_cnt)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, scoreboarded random model run and counter saturation checks
module tb_fetch_ctrl;
  typedef struct packed {
    logic        rst, load_use, mem_busy, br_taken;
    logic [29:0] br_target;
    logic        halt_req, resume;
  } in_t;
  typedef struct packed {
    logic        if_stall, if_branch;
    logic [29:0] addr;
    logic        flush_id, flush_ex, bubble_ex, halted;
    logic [15:0] sc, fc;
  } out_t;
  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst, load_use, mem_busy, br_taken, halt_req, resume;
  logic [29:0] br_target;
  logic        if_stall, if_branch, flush_id, flush_ex, bubble_ex, halted;
  logic [29:0] if_branch_addr;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s4_stall, s4_branch, s4_fid, s4_fex, s4_bubble, s4_halted;
  logic [29:0] s4_addr;
  logic [3:0]  s4_sc, s4_fc;
  int          passed = 0;
  int          total = 0;
  vec_t        tbl [26];
  out_t        exp_q [$];
  logic [1:0]  m_state;
  logic [29:0] m_tgt;
  logic [15:0] m_sc, m_fc;
  always #5 clk = ~clk;
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .load_use(load_use), .mem_busy(mem_busy), .br_taken(br_taken),
    .br_target(br_target), .halt_req(halt_req), .resume(resume), .if_stall(if_stall),
    .if_branch(if_branch), .if_branch_addr(if_branch_addr), .flush_id(flush_id),
    .flush_ex(flush_ex), .bubble_ex(bubble_ex), .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );
  fetch_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .load_use(load_use), .mem_busy(mem_busy), .br_taken(br_taken),
    .br_target(br_target), .halt_req(halt_req), .resume(resume), .if_stall(s4_stall),
    .if_branch(s4_branch), .if_branch_addr(s4_addr), .flush_id(s4_fid),
    .flush_ex(s4_fex), .bubble_ex(s4_bubble), .halted(s4_halted), .stall_cnt(s4_sc),
    .flush_cnt(s4_fc)
  );
  function automatic in_t mk_in(logic r, logic lu, logic mb, logic bt, logic [29:0] t, logic hr, logic rs);
    in_t v;
    v = {r, lu, mb, bt, t, hr, rs};
    return v;
  endfunction
  function automatic out_t mk_out(logic st, logic br, logic [29:0] a, logic fl, logic bu, logic h,
                                  logic [15:0] sc, logic [15:0] fc);
    out_t o;
    o = {st, br, a, fl, fl, bu, h, sc, fc};
    return o;
  endfunction
  task automatic drive(input in_t v);
    @(negedge clk);
    rst = v.rst; load_use = v.load_use; mem_busy = v.mem_busy; br_taken = v.br_taken;
    br_target = v.br_target; halt_req = v.halt_req; resume = v.resume;
  endtask
  task automatic check_pop(input string name);
    out_t e, a;
    #1;
    a = {if_stall, if_branch, if_branch_addr, flush_id, flush_ex, bubble_ex, halted, stall_cnt, flush_cnt};
    total++;
    if (exp_q.size() == 0) $display("FAIL %s scoreboard empty", name);
    else begin
      e = exp_q.pop_front();
      if (a !== e) $display("FAIL %s got %h expected %h", name, a, e);
      else passed++;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) $display("FAIL %s got %0h expected %0h", name, got, want);
    else passed++;
  endtask
  initial begin
    in_t  v;
    out_t e;
    tbl[0]  = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,0,30'h0,0,0,0,16'd0,16'd0)};
    tbl[1]  = {mk_in(0,0,0,1,30'h100,0,0), mk_out(0,0,30'h0,0,0,0,16'd0,16'd0)};
    tbl[2]  = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,1,30'h100,1,0,0,16'd0,16'd0)};
    tbl[3]  = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,0,30'h0,0,0,0,16'd0,16'd1)};
    tbl[4]  = {mk_in(0,0,1,1,30'h40,0,0),  mk_out(1,0,30'h0,0,0,0,16'd0,16'd1)};
    tbl[5]  = {mk_in(0,0,1,1,30'h80,0,0),  mk_out(1,0,30'h0,0,0,0,16'd1,16'd1)};
    tbl[6]  = {mk_in(0,0,1,0,30'h80,0,0),  mk_out(1,0,30'h0,0,0,0,16'd2,16'd1)};
    tbl[7]  = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,0,30'h0,0,0,0,16'd3,16'd1)};
    tbl[8]  = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,1,30'h40,1,0,0,16'd3,16'd1)};
    tbl[9]  = {mk_in(0,1,0,1,30'h200,0,0), mk_out(0,0,30'h0,0,0,0,16'd3,16'd2)};
    tbl[10] = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,1,30'h200,1,0,0,16'd3,16'd2)};
    tbl[11] = {mk_in(0,1,0,0,30'h0,0,0),   mk_out(1,0,30'h0,0,1,0,16'd3,16'd3)};
    tbl[12] = {mk_in(0,0,0,0,30'h0,1,0),   mk_out(0,0,30'h0,0,0,0,16'd4,16'd3)};
    tbl[13] = {mk_in(0,0,0,0,30'h0,1,0),   mk_out(1,0,30'h0,0,0,1,16'd4,16'd3)};
    tbl[14] = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(1,0,30'h0,0,0,1,16'd5,16'd3)};
    tbl[15] = {mk_in(0,0,0,0,30'h0,0,1),   mk_out(1,0,30'h0,0,0,1,16'd6,16'd3)};
    tbl[16] = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,0,30'h0,0,0,0,16'd7,16'd3)};
    tbl[17] = {mk_in(0,0,0,0,30'h0,0,1),   mk_out(0,0,30'h0,0,0,0,16'd7,16'd3)};
    tbl[18] = {mk_in(0,0,1,0,30'h0,1,0),   mk_out(1,0,30'h0,0,0,0,16'd7,16'd3)};
    tbl[19] = {mk_in(0,0,0,1,30'h3,1,0),   mk_out(0,0,30'h0,0,0,0,16'd8,16'd3)};
    tbl[20] = {mk_in(0,0,0,0,30'h0,1,0),   mk_out(0,1,30'h3,1,0,0,16'd8,16'd3)};
    tbl[21] = {mk_in(0,0,0,0,30'h0,0,1),   mk_out(1,0,30'h0,0,0,1,16'd8,16'd4)};
    tbl[22] = {mk_in(0,0,1,1,30'h55,0,0),  mk_out(1,0,30'h0,0,0,0,16'd9,16'd4)};
    tbl[23] = {mk_in(1,0,1,0,30'h0,0,0),   mk_out(1,0,30'h0,0,0,0,16'd10,16'd4)};
    tbl[24] = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,0,30'h0,0,0,0,16'd0,16'd0)};
    tbl[25] = {mk_in(0,0,0,0,30'h0,0,0),   mk_out(0,0,30'h0,0,0,0,16'd0,16'd0)};
    drive(mk_in(1,0,0,0,30'h0,0,0));
    drive(mk_in(1,0,0,0,30'h0,0,0));
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].i);
      exp_q.push_back(tbl[i].o);
      check_pop($sformatf("vec%0d", i));
    end
    // independent reference model, scoreboarded against random stimulus
    drive(mk_in(1,0,0,0,30'h0,0,0));
    m_state = 2'd0; m_tgt = '0; m_sc = '0; m_fc = '0;
    for (int n = 0; n < 400; n++) begin
      v = mk_in($urandom_range(0,49) == 0, 1'($urandom), $urandom_range(0,2) == 0,
                $urandom_range(0,3) == 0, 30'($urandom), $urandom_range(0,7) == 0,
                $urandom_range(0,3) == 0);
      if (m_state == 2'd2) v.mem_busy = 1'b0;
      drive(v);
      e.halted    = m_state == 2'd3;
      e.if_branch = m_state == 2'd2;
      e.flush_id  = e.if_branch;
      e.flush_ex  = e.if_branch;
      e.addr      = e.if_branch ? m_tgt : 30'h0;
      e.if_stall  = e.halted || v.mem_busy || (v.load_use && !v.br_taken && m_state != 2'd2 && m_state != 2'd1);
      e.bubble_ex = v.load_use && !v.mem_busy && !v.br_taken && m_state == 2'd0;
      e.sc = m_sc;
      e.fc = m_fc;
      exp_q.push_back(e);
      check_pop($sformatf("rnd%0d", n));
      if (v.rst) begin
        m_state = 2'd0; m_tgt = '0; m_sc = '0; m_fc = '0;
      end else begin
        if (e.if_stall && m_sc != 16'hffff) m_sc = m_sc + 16'd1;
        if (e.if_branch && m_fc != 16'hffff) m_fc = m_fc + 16'd1;
        case (m_state)
          2'd0: begin
            if (v.br_taken) begin
              m_tgt = v.br_target;
              m_state = v.mem_busy ? 2'd1 : 2'd2;
            end else if (v.halt_req && !v.mem_busy) m_state = 2'd3;
          end
          2'd1: if (!v.mem_busy) m_state = 2'd2;
          2'd2: m_state = v.halt_req ? 2'd3 : 2'd0;
          default: if (v.resume) m_state = 2'd0;
        endcase
      end
    end
    // 4-bit counter saturation, then reset in the middle of a pending redirect
    drive(mk_in(1,0,0,0,30'h0,0,0));
    drive(mk_in(0,0,1,1,30'h77,0,0));
    for (int k = 0; k < 19; k++) drive(mk_in(0,0,1,0,30'h0,0,0));
    drive(mk_in(1,0,1,0,30'h0,0,0));
    #1;
    chk("sat4_stall_cnt", 32'(s4_sc), 32'd15);
    chk("sat16_stall_cnt", 32'(stall_cnt), 32'd20);
    chk("pend_if_stall", 32'(s4_stall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(mk_in(0,0,0,0,30'h0,0,0));
      #1;
      chk($sformatf("post_rst_branch%0d", k), {31'd0, if_branch}, 32'd0);
      chk($sformatf("post_rst_branch4_%0d", k), {s4_fc, 15'd0, s4_branch}, 32'd0);
      chk($sformatf("post_rst_addr%0d", k), 32'(if_branch_addr), 32'd0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
